// File: rtl/tl_a_arb2_if.sv
// rtl/tl_a_arb2_if.sv - upstream/downstream TileLink-UL A/D bundle for the 2:1 arbiter
// The arbiter takes the master modport; the environment around it takes slave.
interface tl_a_arb2_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 9
);
   logic              a0_valid;
   logic              a0_ready;
   logic [2:0]        a0_opcode;
   logic [2:0]        a0_param;
   logic [1:0]        a0_size;
   logic              a0_source;
   logic [ADDR_W-1:0] a0_address;
   logic [3:0]        a0_mask;
   logic [DATA_W-1:0] a0_data;
   logic              a0_corrupt;

   logic              a1_valid;
   logic              a1_ready;
   logic [2:0]        a1_opcode;
   logic [2:0]        a1_param;
   logic [1:0]        a1_size;
   logic              a1_source;
   logic [ADDR_W-1:0] a1_address;
   logic [3:0]        a1_mask;
   logic [DATA_W-1:0] a1_data;
   logic              a1_corrupt;

   logic              out_a_valid;
   logic              out_a_ready;
   logic [2:0]        out_a_opcode;
   logic [2:0]        out_a_param;
   logic [1:0]        out_a_size;
   logic [1:0]        out_a_source;
   logic [ADDR_W-1:0] out_a_address;
   logic [3:0]        out_a_mask;
   logic [DATA_W-1:0] out_a_data;
   logic              out_a_corrupt;

   logic              out_d_valid;
   logic              out_d_ready;
   logic [2:0]        out_d_opcode;
   logic [1:0]        out_d_size;
   logic [1:0]        out_d_source;
   logic [DATA_W-1:0] out_d_data;
   logic              out_d_denied;
   logic              out_d_corrupt;

   logic              d0_valid;
   logic              d0_ready;
   logic [2:0]        d0_opcode;
   logic [1:0]        d0_size;
   logic              d0_source;
   logic [DATA_W-1:0] d0_data;
   logic              d0_denied;
   logic              d0_corrupt;

   logic              d1_valid;
   logic              d1_ready;
   logic [2:0]        d1_opcode;
   logic [1:0]        d1_size;
   logic              d1_source;
   logic [DATA_W-1:0] d1_data;
   logic              d1_denied;
   logic              d1_corrupt;

   logic              sel;
   logic              busy;

   modport master (
      input  a0_valid, a0_opcode, a0_param, a0_size, a0_source, a0_address, a0_mask, a0_data, a0_corrupt,
      output a0_ready,
      input  a1_valid, a1_opcode, a1_param, a1_size, a1_source, a1_address, a1_mask, a1_data, a1_corrupt,
      output a1_ready,
      output out_a_valid, out_a_opcode, out_a_param, out_a_size, out_a_source, out_a_address,
             out_a_mask, out_a_data, out_a_corrupt,
      input  out_a_ready,
      input  out_d_valid, out_d_opcode, out_d_size, out_d_source, out_d_data, out_d_denied, out_d_corrupt,
      output out_d_ready,
      output d0_valid, d0_opcode, d0_size, d0_source, d0_data, d0_denied, d0_corrupt,
      input  d0_ready,
      output d1_valid, d1_opcode, d1_size, d1_source, d1_data, d1_denied, d1_corrupt,
      input  d1_ready,
      output sel, busy
   );

   modport slave (
      output a0_valid, a0_opcode, a0_param, a0_size, a0_source, a0_address, a0_mask, a0_data, a0_corrupt,
      input  a0_ready,
      output a1_valid, a1_opcode, a1_param, a1_size, a1_source, a1_address, a1_mask, a1_data, a1_corrupt,
      input  a1_ready,
      input  out_a_valid, out_a_opcode, out_a_param, out_a_size, out_a_source, out_a_address,
             out_a_mask, out_a_data, out_a_corrupt,
      output out_a_ready,
      output out_d_valid, out_d_opcode, out_d_size, out_d_source, out_d_data, out_d_denied, out_d_corrupt,
      input  out_d_ready,
      input  d0_valid, d0_opcode, d0_size, d0_source, d0_data, d0_denied, d0_corrupt,
      output d0_ready,
      input  d1_valid, d1_opcode, d1_size, d1_source, d1_data, d1_denied, d1_corrupt,
      output d1_ready,
      input  sel, busy
   );
endinterface

// File: rtl/tl_a_arb2.sv
// rtl/tl_a_arb2.sv - 2:1 TileLink-UL A-channel arbiter, round-robin with burst lock
// D responses are steered back by the requester bit carried in source[1].
module tl_a_arb2 #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 9
) (
   input logic        clock,
   input logic        reset_n,
   tl_a_arb2_if.master bus
);
   typedef enum logic {IDLE, BURST} state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_rr;
   logic              r_owner;
   logic              r_sel;
   logic [1:0]        r_beats_left;
   logic              w_rr_nxt;
   logic              w_owner_nxt;
   logic [1:0]        w_beats_nxt;

   logic              w_sel;
   logic              w_fire;
   logic              w_a_valid;
   logic [2:0]        w_a_opcode;
   logic [1:0]        w_a_size;
   logic [1:0]        w_beats_m1;
   logic [ADDR_W-1:0] w_a_address;
   logic [DATA_W-1:0] w_a_data;

   // Grant is forced to requester 0 while reset is held so nothing leaks out.
   always_comb begin
      w_sel = r_sel;
      if (!reset_n)
         w_sel = 1'b0;
      else if (r_state == BURST)
         w_sel = r_owner;
      else if (bus.a0_valid && bus.a1_valid)
         w_sel = r_rr;
      else if (bus.a0_valid)
         w_sel = 1'b0;
      else if (bus.a1_valid)
         w_sel = 1'b1;
   end

   assign w_a_valid   = reset_n & (w_sel ? bus.a1_valid : bus.a0_valid);
   assign w_a_opcode  = w_sel ? bus.a1_opcode  : bus.a0_opcode;
   assign w_a_size    = w_sel ? bus.a1_size    : bus.a0_size;
   assign w_a_address = w_sel ? bus.a1_address : bus.a0_address;
   assign w_a_data    = w_sel ? bus.a1_data    : bus.a0_data;
   assign w_fire      = w_a_valid & bus.out_a_ready;

   assign w_beats_m1 = (w_a_opcode < 3'd4 && w_a_size > 2'd2) ?
                       2'((3'd1 << (w_a_size - 2'd2)) - 3'd1) : 2'd0;

   assign bus.out_a_valid   = w_a_valid;
   assign bus.out_a_opcode  = w_a_opcode;
   assign bus.out_a_param   = w_sel ? bus.a1_param   : bus.a0_param;
   assign bus.out_a_size    = w_a_size;
   assign bus.out_a_source  = {w_sel, (w_sel ? bus.a1_source : bus.a0_source)};
   assign bus.out_a_address = w_a_address;
   assign bus.out_a_mask    = w_sel ? bus.a1_mask    : bus.a0_mask;
   assign bus.out_a_data    = w_a_data;
   assign bus.out_a_corrupt = w_sel ? bus.a1_corrupt : bus.a0_corrupt;
   assign bus.a0_ready      = reset_n & ~w_sel & bus.out_a_ready;
   assign bus.a1_ready      = reset_n &  w_sel & bus.out_a_ready;
   assign bus.sel           = w_sel;
   assign bus.busy          = (r_state == BURST);

   always_comb begin
      w_state_nxt = r_state;
      w_rr_nxt    = r_rr;
      w_owner_nxt = r_owner;
      w_beats_nxt = r_beats_left;
      case (r_state)
         IDLE: begin
            if (w_fire) begin
               if (w_beats_m1 == 2'd0) begin
                  w_rr_nxt = ~w_sel;
               end else begin
                  w_owner_nxt = w_sel;
                  w_beats_nxt = w_beats_m1;
                  w_state_nxt = BURST;
               end
            end
         end
         BURST: begin
            if (w_fire) begin
               w_beats_nxt = r_beats_left - 2'd1;
               if (r_beats_left == 2'd1) begin
                  w_state_nxt = IDLE;
                  w_rr_nxt    = ~r_owner;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= IDLE;
         r_rr         <= 1'b0;
         r_owner      <= 1'b0;
         r_beats_left <= 2'd0;
         r_sel        <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_rr         <= w_rr_nxt;
         r_owner      <= w_owner_nxt;
         r_beats_left <= w_beats_nxt;
         r_sel        <= w_sel;
      end
   end

   assign bus.out_d_ready = bus.out_d_source[1] ? bus.d1_ready : bus.d0_ready;

   assign bus.d0_valid   = bus.out_d_valid & ~bus.out_d_source[1];
   assign bus.d0_opcode  = bus.out_d_opcode;
   assign bus.d0_size    = bus.out_d_size;
   assign bus.d0_source  = bus.out_d_source[0];
   assign bus.d0_data    = bus.out_d_data;
   assign bus.d0_denied  = bus.out_d_denied;
   assign bus.d0_corrupt = bus.out_d_corrupt;

   assign bus.d1_valid   = bus.out_d_valid & bus.out_d_source[1];
   assign bus.d1_opcode  = bus.out_d_opcode;
   assign bus.d1_size    = bus.out_d_size;
   assign bus.d1_source  = bus.out_d_source[0];
   assign bus.d1_data    = bus.out_d_data;
   assign bus.d1_denied  = bus.out_d_denied;
   assign bus.d1_corrupt = bus.out_d_corrupt;
endmodule
